// File: rtl/psum_line_fifo_pkg.sv
// rtl/psum_line_fifo_pkg.sv - shared defaults and control-FSM encodings for the psum line FIFO
package psum_line_fifo_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;
  localparam int PTR_W      = $clog2(DEPTH_DEF);

  // One-hot control states: FLUSH holds everything at reset values for one
  // cycle after rstn release, RUN is normal operation.
  typedef enum logic [1:0] {
    ST_FLUSH = 2'b01,
    ST_RUN   = 2'b10
  } psum_state_e;

endpackage

// File: rtl/psum_fifo_ram.sv
// rtl/psum_fifo_ram.sv - simple dual-port storage, sync write / async read
//
// Ports:
//   clk    in  clock, rising edge
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data, combinational from raddr
//
// Storage has no reset; kept as its own module so a registered-output SRAM
// macro can replace it later.
module psum_fifo_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/psum_line_fifo.sv
// rtl/psum_line_fifo.sv - FWFT partial-sum line buffer between convolution row passes
//
// Ports:
//   clk, rstn           clock (rising edge), async active-low reset
//   clr                 sync flush of pointers, level and error flags
//   wr_cs, wr_en        push request when both high
//   data_in             write data
//   full, almost_full   level == DEPTH, level >= AF_THRESH
//   rd_cs, rd_en        pop request when both high
//   data_out            head word (first-word-fall-through), 0 when empty
//   empty               level == 0
//   level               occupancy, 0..DEPTH
//   overflow, underflow sticky: push while full / pop while empty
module psum_line_fifo
  import psum_line_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AF_THRESH = 240,
  parameter int AW        = $clog2(DEPTH),
  parameter int LW        = AW + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              wr_cs,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_cs,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic              underflow
);

  psum_state_e       state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              run;
  logic              push_req, pop_req;
  logic              push_ok, pop_ok;
  logic [DATA_W-1:0] ram_rdata;

  // Control FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_FLUSH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FLUSH: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_FLUSH;
    endcase
  end

  assign run = (state_q == ST_RUN);

  // Status is derived from the registered level, so acceptance below always
  // uses the flags as they were before the edge.
  assign empty       = (level_q == '0);
  assign full        = (level_q == LW'(DEPTH));
  assign almost_full = (level_q >= LW'(AF_THRESH));
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  assign push_req = wr_cs & wr_en;
  assign pop_req  = rd_cs & rd_en;
  // clr discards any request issued in the same cycle.
  assign push_ok  = run & ~clr & push_req & ~full;
  assign pop_ok   = run & ~clr & pop_req & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (run) begin
      if (clr) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        level_d  = '0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
      end else begin
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push_ok, pop_ok})
          2'b10:   level_d = level_q + LW'(1);
          2'b01:   level_d = level_q - LW'(1);
          default: level_d = level_q;
        endcase
        if (push_req & full)  ovf_d = 1'b1;
        if (pop_req  & empty) unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  psum_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign data_out = empty ? '0 : ram_rdata;

endmodule
